// File: rtl/csa_final_adder_pkg.sv
// ---------------------------------------------------------------------------
// csa_final_adder_pkg
//   Shared definitions for the carry-save final adder block.
//   - state_e     : FSM state encoding (ST_IDLE / ST_ADD / ST_DONE)
//   - DEF_WIDTH   : default operand/result width (matches the CSA vector width)
//   - DEF_CHUNK   : default number of bits resolved per ADD cycle
// ---------------------------------------------------------------------------
package csa_final_adder_pkg;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_ADD  = 2'd1,
    ST_DONE = 2'd2
  } state_e;

  localparam int DEF_WIDTH = 20;
  localparam int DEF_CHUNK = 4;

endpackage

// File: rtl/csa_final_adder_if.sv
// ---------------------------------------------------------------------------
// csa_final_adder_if
//   Operand/result handshake bundle of the final adder.
//   Operand side : in_valid, in_ready, s_in (CSA sum), c_in (CSA carry, pre-shifted)
//   Result side  : out_valid, out_ready, result, cout
//   master : producer/consumer around the adder (drives operands and out_ready)
//   slave  : the adder itself
// ---------------------------------------------------------------------------
interface csa_final_adder_if
  import csa_final_adder_pkg::*;
#(
  parameter int WIDTH = DEF_WIDTH
);

  logic             in_valid;
  logic             in_ready;
  logic [WIDTH-1:0] s_in;
  logic [WIDTH-1:0] c_in;
  logic             out_valid;
  logic             out_ready;
  logic [WIDTH-1:0] result;
  logic             cout;

  modport master (
    output in_valid, s_in, c_in, out_ready,
    input  in_ready, out_valid, result, cout
  );

  modport slave (
    input  in_valid, s_in, c_in, out_ready,
    output in_ready, out_valid, result, cout
  );

endinterface

// File: rtl/csa_final_adder_cpa_chunk.sv
// ---------------------------------------------------------------------------
// cpa_chunk
//   CHUNK-bit ripple-carry adder made of full-adder cells.
//   a_i, b_i : CHUNK-bit addends
//   cin_i    : carry into bit 0
//   sum_o    : CHUNK-bit sum
//   cout_o   : carry out of bit CHUNK-1
// ---------------------------------------------------------------------------
module cpa_chunk
  import csa_final_adder_pkg::*;
#(
  parameter int CHUNK = DEF_CHUNK
) (
  input  logic [CHUNK-1:0] a_i,
  input  logic [CHUNK-1:0] b_i,
  input  logic             cin_i,
  output logic [CHUNK-1:0] sum_o,
  output logic             cout_o
);

  // Carry is walked through a procedural variable so the ripple is a
  // straight chain rather than a self-referencing vector.
  always_comb begin
    logic carry;
    carry = cin_i;
    sum_o = '0;
    for (int i = 0; i < CHUNK; i++) begin
      sum_o[i] = a_i[i] ^ b_i[i] ^ carry;
      carry    = (a_i[i] & b_i[i]) | (carry & (a_i[i] ^ b_i[i]));
    end
    cout_o = carry;
  end

endmodule

// File: rtl/csa_final_adder.sv
// ---------------------------------------------------------------------------
// csa_final_adder
//   Sequential carry-propagate adder that resolves the CSA sum and carry
//   vectors into one binary result, CHUNK bits per clock.
//   clk   : rising-edge clock
//   rst_n : asynchronous active-low reset
//   bus   : slave side of csa_final_adder_if
//           in_valid/in_ready/s_in/c_in   operand handshake (ready only in IDLE)
//           out_valid/out_ready/result/cout result handshake (registered)
//   Accept on edge k -> out_valid after edge k+NCHUNK; held until out_ready.
// ---------------------------------------------------------------------------
module csa_final_adder
  import csa_final_adder_pkg::*;
#(
  parameter int WIDTH = DEF_WIDTH,
  parameter int CHUNK = DEF_CHUNK
) (
  input  logic              clk,
  input  logic              rst_n,
  csa_final_adder_if.slave  bus
);

  localparam int NCHUNK = WIDTH / CHUNK;
  localparam int CNT_W  = $clog2(NCHUNK + 1);

  if (WIDTH % CHUNK != 0) begin : g_bad_chunk
    $error("csa_final_adder: WIDTH must be a multiple of CHUNK");
  end

  state_e             state_q,     state_d;
  logic [WIDTH-1:0]   s_q,         s_d;
  logic [WIDTH-1:0]   c_q,         c_d;
  logic [WIDTH-1:0]   res_q,       res_d;
  logic               carry_q,     carry_d;
  logic [CNT_W-1:0]   cnt_q,       cnt_d;
  logic [WIDTH-1:0]   result_q,    result_d;
  logic               cout_q,      cout_d;
  logic               out_valid_q, out_valid_d;

  logic [CHUNK-1:0]   chunk_sum;
  logic               chunk_cout;

  // The low chunk of the operand shift registers is always the one in flight.
  cpa_chunk #(.CHUNK(CHUNK)) u_chunk (
    .a_i    (s_q[CHUNK-1:0]),
    .b_i    (c_q[CHUNK-1:0]),
    .cin_i  (carry_q),
    .sum_o  (chunk_sum),
    .cout_o (chunk_cout)
  );

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q     <= ST_IDLE;
      s_q         <= '0;
      c_q         <= '0;
      res_q       <= '0;
      carry_q     <= 1'b0;
      cnt_q       <= '0;
      result_q    <= '0;
      cout_q      <= 1'b0;
      out_valid_q <= 1'b0;
    end else begin
      state_q     <= state_d;
      s_q         <= s_d;
      c_q         <= c_d;
      res_q       <= res_d;
      carry_q     <= carry_d;
      cnt_q       <= cnt_d;
      result_q    <= result_d;
      cout_q      <= cout_d;
      out_valid_q <= out_valid_d;
    end
  end

  always_comb begin
    state_d     = state_q;
    s_d         = s_q;
    c_d         = c_q;
    res_d       = res_q;
    carry_d     = carry_q;
    cnt_d       = cnt_q;
    result_d    = result_q;
    cout_d      = cout_q;
    out_valid_d = out_valid_q;

    unique case (state_q)
      ST_IDLE: begin
        if (bus.in_valid) begin
          s_d     = bus.s_in;
          c_d     = bus.c_in;
          carry_d = 1'b0;
          cnt_d   = '0;
          state_d = ST_ADD;
        end
      end

      ST_ADD: begin
        // New chunk enters at the top, so after NCHUNK shifts chunk 0
        // has arrived at bit 0.
        res_d   = {chunk_sum, res_q[WIDTH-1:CHUNK]};
        s_d     = s_q >> CHUNK;
        c_d     = c_q >> CHUNK;
        carry_d = chunk_cout;
        cnt_d   = cnt_q + 1'b1;
        if (cnt_q == CNT_W'(NCHUNK - 1)) begin
          result_d    = res_d;
          cout_d      = chunk_cout;
          out_valid_d = 1'b1;
          state_d     = ST_DONE;
        end
      end

      ST_DONE: begin
        if (bus.out_ready) begin
          out_valid_d = 1'b0;
          state_d     = ST_IDLE;
        end
      end

      default: state_d = ST_IDLE;
    endcase
  end

  assign bus.in_ready  = (state_q == ST_IDLE);
  assign bus.out_valid = out_valid_q;
  assign bus.result    = result_q;
  assign bus.cout      = cout_q;

endmodule

// File: tb/tb_csa_final_adder.sv
module tb_csa_final_adder;

  localparam int W = 20;

  logic clk = 1'b0;
  logic rst_n;
  int   errors = 0;
  int   checks = 0;

  always #5 clk = ~clk;

  csa_final_adder_if #(.WIDTH(W)) bus ();

  csa_final_adder #(.WIDTH(W), .CHUNK(4)) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus.slave)
  );

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  // Present one operand pair for one edge (IDLE assumed), then scramble the
  // inputs so later sampling would be visible.
  task automatic send(input logic [W-1:0] s, input logic [W-1:0] c);
    bus.s_in     = s;
    bus.c_in     = c;
    bus.in_valid = 1'b1;
    step();
    bus.in_valid = 1'b0;
    bus.s_in     = ~s;
    bus.c_in     = ~c;
  endtask

  // Count edges until out_valid, bounded by max.
  task automatic wait_valid(input int max, output int n);
    n = 0;
    while (n < max && bus.out_valid !== 1'b1) begin
      step();
      n++;
    end
  endtask

  task automatic test_reset();
    rst_n         = 1'b0;
    bus.in_valid  = 1'b0;
    bus.out_ready = 1'b0;
    bus.s_in      = '0;
    bus.c_in      = '0;
    #12;
    checks++;
    if (bus.in_ready !== 1'b1) begin
      errors++; $display("FAIL reset_in_ready got=%b exp=1", bus.in_ready);
    end
    checks++;
    if (bus.out_valid !== 1'b0) begin
      errors++; $display("FAIL reset_out_valid got=%b exp=0", bus.out_valid);
    end
    checks++;
    if (bus.result !== 20'h00000 || bus.cout !== 1'b0) begin
      errors++; $display("FAIL reset_result got=%h/%b exp=00000/0", bus.result, bus.cout);
    end
    @(negedge clk);
    rst_n = 1'b1;
    step();
  endtask

  task automatic test_basic();
    int n;
    send(20'h00001, 20'h00001);
    checks++;
    if (bus.in_ready !== 1'b0) begin
      errors++; $display("FAIL basic_busy in_ready got=%b exp=0", bus.in_ready);
    end
    wait_valid(10, n);
    checks++;
    if (n != 5 || bus.out_valid !== 1'b1) begin
      errors++; $display("FAIL basic_latency edges got=%0d exp=5", n);
    end
    checks++;
    if (bus.result !== 20'h00002 || bus.cout !== 1'b0) begin
      errors++; $display("FAIL basic_sum got=%h/%b exp=00002/0", bus.result, bus.cout);
    end
    bus.out_ready = 1'b1;
    step();
    bus.out_ready = 1'b0;
    checks++;
    if (bus.out_valid !== 1'b0 || bus.in_ready !== 1'b1) begin
      errors++; $display("FAIL basic_handshake out_valid=%b in_ready=%b exp=0/1",
                         bus.out_valid, bus.in_ready);
    end
  endtask

  task automatic test_full_ripple();
    int n;
    send(20'hFFFFF, 20'h00001);
    wait_valid(10, n);
    checks++;
    if (n != 5 || bus.result !== 20'h00000 || bus.cout !== 1'b1) begin
      errors++; $display("FAIL ripple got=%h/%b n=%0d exp=00000/1 n=5",
                         bus.result, bus.cout, n);
    end
    bus.out_ready = 1'b1;
    step();
    bus.out_ready = 1'b0;
  endtask

  task automatic test_stall();
    int n;
    send(20'h0000F, 20'h00010);
    wait_valid(10, n);
    checks++;
    if (n != 5 || bus.result !== 20'h0001F || bus.cout !== 1'b0) begin
      errors++; $display("FAIL stall_sum got=%h/%b n=%0d exp=0001F/0", bus.result, bus.cout, n);
    end
    for (int i = 0; i < 3; i++) begin
      step();
      checks++;
      if (bus.out_valid !== 1'b1 || bus.in_ready !== 1'b0 || bus.result !== 20'h0001F) begin
        errors++; $display("FAIL stall_hold cyc=%0d out_valid=%b in_ready=%b result=%h exp=1/0/0001F",
                           i, bus.out_valid, bus.in_ready, bus.result);
      end
    end
    bus.out_ready = 1'b1;
    step();
    bus.out_ready = 1'b0;
    checks++;
    if (bus.out_valid !== 1'b0 || bus.in_ready !== 1'b1) begin
      errors++; $display("FAIL stall_release out_valid=%b in_ready=%b exp=0/1",
                         bus.out_valid, bus.in_ready);
    end
  endtask

  task automatic test_reset_mid_add();
    int seen;
    send(20'h12345, 20'h11110);
    step();
    step();
    // Third ADD cycle: assert reset between edges.
    rst_n = 1'b0;
    #2;
    checks++;
    if (bus.out_valid !== 1'b0 || bus.result !== 20'h00000 || bus.cout !== 1'b0 ||
        bus.in_ready !== 1'b1) begin
      errors++; $display("FAIL abort_async out_valid=%b result=%h cout=%b in_ready=%b exp=0/00000/0/1",
                         bus.out_valid, bus.result, bus.cout, bus.in_ready);
    end
    #1;
    rst_n = 1'b1;
    bus.out_ready = 1'b1;
    seen = 0;
    for (int i = 0; i < 8; i++) begin
      step();
      if (bus.out_valid === 1'b1) seen++;
    end
    bus.out_ready = 1'b0;
    checks++;
    if (seen != 0 || bus.in_ready !== 1'b1) begin
      errors++; $display("FAIL abort_no_output pulses=%0d in_ready=%b exp=0/1", seen, bus.in_ready);
    end
  endtask

  task automatic test_back_to_back();
    logic [W-1:0] ps [3];
    logic [W-1:0] pc [3];
    logic [W:0]   ex [3];
    logic [W:0]   got [3];
    int           got_cyc [3];
    int           acc_cyc [3];
    int           acc_n;
    int           got_n;
    ps[0] = 20'h12345; pc[0] = 20'h0ABC0; ex[0] = 21'h01CF05;
    ps[1] = 20'h80000; pc[1] = 20'h80000; ex[1] = 21'h100000;
    ps[2] = 20'hF0F0F; pc[2] = 20'h0F0F0; ex[2] = 21'h0FFFFF;
    acc_n = 0;
    got_n = 0;
    for (int i = 0; i < 3; i++) begin
      got[i] = '0; got_cyc[i] = 0; acc_cyc[i] = 0;
    end
    bus.out_ready = 1'b1;
    bus.s_in      = ps[0];
    bus.c_in      = pc[0];
    bus.in_valid  = 1'b1;
    for (int cyc = 0; cyc < 40; cyc++) begin
      logic acc;
      logic hs;
      acc = bus.in_valid && bus.in_ready;
      hs  = bus.out_valid && bus.out_ready;
      if (hs) begin
        if (got_n < 3) begin
          got[got_n]     = {bus.cout, bus.result};
          got_cyc[got_n] = cyc;
        end
        got_n++;
      end
      step();
      if (acc) begin
        if (acc_n < 3) acc_cyc[acc_n] = cyc;
        acc_n++;
        if (acc_n < 3) begin
          bus.s_in = ps[acc_n];
          bus.c_in = pc[acc_n];
        end else begin
          bus.in_valid = 1'b0;
        end
      end
    end
    bus.in_valid  = 1'b0;
    bus.out_ready = 1'b0;
    checks++;
    if (got_n != 3 || acc_n != 3) begin
      errors++; $display("FAIL b2b_count results=%0d accepts=%0d exp=3/3", got_n, acc_n);
    end
    for (int i = 0; i < 3; i++) begin
      checks++;
      if (got[i] !== ex[i]) begin
        errors++; $display("FAIL b2b_result idx=%0d got=%h exp=%h", i, got[i], ex[i]);
      end
    end
    checks++;
    if (got_cyc[0] - acc_cyc[0] != 6 || got_cyc[1] - got_cyc[0] != 7 ||
        got_cyc[2] - got_cyc[1] != 7) begin
      errors++; $display("FAIL b2b_spacing cycles=%0d,%0d,%0d accept0=%0d exp=6,13,20 accept0=0",
                         got_cyc[0], got_cyc[1], got_cyc[2], acc_cyc[0]);
    end
  endtask

  task automatic test_random();
    logic [W-1:0] s;
    logic [W-1:0] c;
    logic [W:0]   ex;
    int           n;
    int           stall;
    for (int i = 0; i < 1000; i++) begin
      s    = W'($urandom);
      c    = W'($urandom);
      c[0] = 1'b0;
      ex   = {1'b0, s} + {1'b0, c};
      send(s, c);
      wait_valid(10, n);
      checks++;
      if (bus.out_valid !== 1'b1 || {bus.cout, bus.result} !== ex) begin
        errors++; $display("FAIL rand_sum idx=%0d s=%h c=%h got=%b/%h exp=%h",
                           i, s, c, bus.cout, bus.result, ex);
      end
      stall = $urandom_range(0, 3);
      repeat (stall) step();
      checks++;
      if (bus.out_valid !== 1'b1 || {bus.cout, bus.result} !== ex) begin
        errors++; $display("FAIL rand_hold idx=%0d got=%b/%h exp=%h",
                           i, bus.cout, bus.result, ex);
      end
      bus.out_ready = 1'b1;
      step();
      bus.out_ready = 1'b0;
    end
  endtask

  initial begin
    test_reset();
    test_basic();
    test_full_ripple();
    test_stall();
    test_reset_mid_add();
    test_back_to_back();
    test_random();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
